// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter that shares one cache request port among NUM_REQ requesters.
// The granted request sits in a one-entry holding stage. Each grant's source ID
// goes into an in-order tag FIFO, which routes the in-order cache responses back
// to the requester that issued them.
module cache_req_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned DW       = 64,
  parameter int unsigned RW       = 64,
  parameter int unsigned MAX_OUTS = 4,
  parameter int unsigned SW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int unsigned CW       = $clog2(MAX_OUTS + 1)
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  input  logic [NUM_REQ*DW-1:0] req_data_i,
  output logic [NUM_REQ-1:0]    req_allowIn_o,
  output logic                  cache_req_valid_o,
  input  logic                  cache_req_allowIn_i,
  output logic [DW-1:0]         cache_req_o,
  output logic [SW-1:0]         cache_req_src_o,
  input  logic                  cache_resp_valid_i,
  input  logic [RW-1:0]         cache_resp_i,
  output logic [NUM_REQ-1:0]    resp_valid_o,
  output logic [RW-1:0]         resp_data_o,
  output logic [CW-1:0]         outs_cnt_o,
  output logic                  err_o
);

  localparam int unsigned PW = (MAX_OUTS > 1) ? $clog2(MAX_OUTS) : 1;

  logic [SW-1:0] rr_ptr_q, rr_ptr_d;
  logic          hold_valid_q;
  logic [DW-1:0] hold_data_q;
  logic [SW-1:0] hold_src_q;
  logic [SW-1:0] tag_mem_q [MAX_OUTS];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] outs_cnt_q;
  logic          err_q;

  logic          fifo_full, pop, can_grant, grant;
  logic          arb_found;
  logic [SW-1:0] arb_winner;
  logic [SW:0]   arb_sum;

  assign fifo_full = (outs_cnt_q == CW'(MAX_OUTS));
  assign pop       = cache_resp_valid_i & (outs_cnt_q != '0);
  // A response pop frees a FIFO slot in the same cycle, so a full FIFO can still accept.
  assign can_grant = (~hold_valid_q | cache_req_allowIn_i) & (~fifo_full | pop);
  // Gated by reset so the grant strobe reads zero while reset is held.
  assign grant     = arb_found & can_grant & rstn_i;

  // Round-robin search from rr_ptr upward with wrap; first valid requester wins.
  always_comb begin
    arb_found  = 1'b0;
    arb_winner = '0;
    arb_sum    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      arb_sum = {1'b0, rr_ptr_q} + (SW+1)'(k);
      if (arb_sum >= (SW+1)'(NUM_REQ)) begin
        arb_sum = arb_sum - (SW+1)'(NUM_REQ);
      end
      if (!arb_found && req_valid_i[arb_sum[SW-1:0]]) begin
        arb_found  = 1'b1;
        arb_winner = arb_sum[SW-1:0];
      end
    end
  end

  // One-hot grant strobe and pointer advance past the winner.
  always_comb begin
    req_allowIn_o = '0;
    rr_ptr_d      = rr_ptr_q;
    if (grant) begin
      req_allowIn_o[arb_winner] = 1'b1;
      rr_ptr_d = (arb_winner == SW'(NUM_REQ - 1)) ? '0 : arb_winner + SW'(1);
    end
  end

  // Response routing: strobe the requester recorded at the FIFO head.
  always_comb begin
    resp_valid_o = '0;
    if (pop) begin
      resp_valid_o[tag_mem_q[rd_ptr_q]] = 1'b1;
    end
  end

  // Arbitration pointer and holding stage.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rr_ptr_q     <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      hold_src_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (grant) begin
        hold_valid_q <= 1'b1;
        hold_data_q  <= req_data_i[arb_winner*DW +: DW];
        hold_src_q   <= arb_winner;
      end else if (hold_valid_q && cache_req_allowIn_i) begin
        hold_valid_q <= 1'b0;
      end
    end
  end

  // Tag FIFO: circular buffer with explicit wrap so depth need not be a power of two.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int unsigned i = 0; i < MAX_OUTS; i++) begin
        tag_mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      outs_cnt_q <= '0;
    end else begin
      if (grant) begin
        tag_mem_q[wr_ptr_q] <= arb_winner;
        wr_ptr_q <= (wr_ptr_q == PW'(MAX_OUTS - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PW'(MAX_OUTS - 1)) ? '0 : rd_ptr_q + PW'(1);
      end
      if (grant && !pop) begin
        outs_cnt_q <= outs_cnt_q + CW'(1);
      end else if (pop && !grant) begin
        outs_cnt_q <= outs_cnt_q - CW'(1);
      end
    end
  end

  // Sticky error: a response arrived with nothing outstanding.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      err_q <= 1'b0;
    end else if (cache_resp_valid_i && outs_cnt_q == '0) begin
      err_q <= 1'b1;
    end
  end

  assign cache_req_valid_o = hold_valid_q;
  assign cache_req_o       = hold_data_q;
  assign cache_req_src_o   = hold_src_q;
  assign resp_data_o       = cache_resp_i;
  assign outs_cnt_o        = outs_cnt_q;
  assign err_o             = err_q;

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Bench for cache_req_arbiter: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a queue-based model.
module tb_cache_req_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int RW = 64;
  localparam int MO = 4;
  localparam int SW = 2;
  localparam int CW = 3;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_allow;
  logic            creq_valid;
  logic            creq_allow_in;
  logic [DW-1:0]   creq;
  logic [SW-1:0]   creq_src;
  logic            cresp_valid;
  logic [RW-1:0]   cresp;
  logic [N-1:0]    resp_valid;
  logic [RW-1:0]   resp_data;
  logic [CW-1:0]   outs_cnt;
  logic            err;

  int errors = 0;
  int checks = 0;

  cache_req_arbiter #(
    .NUM_REQ (N),
    .DW      (DW),
    .RW      (RW),
    .MAX_OUTS(MO)
  ) dut (
    .clk_i              (clk),
    .rstn_i             (rstn),
    .req_valid_i        (req_valid),
    .req_data_i         (req_data),
    .req_allowIn_o      (req_allow),
    .cache_req_valid_o  (creq_valid),
    .cache_req_allowIn_i(creq_allow_in),
    .cache_req_o        (creq),
    .cache_req_src_o    (creq_src),
    .cache_resp_valid_i (cresp_valid),
    .cache_resp_i       (cresp),
    .resp_valid_o       (resp_valid),
    .resp_data_o        (resp_data),
    .outs_cnt_o         (outs_cnt),
    .err_o              (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: outstanding tags as a queue, holding stage as plain variables.
  int          m_rr;
  int          m_fifo[$];
  bit          m_hv;
  logic [63:0] m_hdata;
  int          m_hsrc;
  bit          m_err;

  // Compare the DUT against the model mid-cycle, then advance the model to the next edge.
  always @(negedge clk) begin : model_cmp
    int           w;
    bit           found, pop, cg, grant;
    logic [N-1:0] e_allow, e_rv;
    if (!rstn) begin
      m_rr = 0;
      m_fifo.delete();
      m_hv    = 1'b0;
      m_hdata = '0;
      m_hsrc  = 0;
      m_err   = 1'b0;
      chk("rst_allow", 64'(req_allow), 64'h0);
      chk("rst_valid", 64'(creq_valid), 64'h0);
      chk("rst_data", 64'(creq), 64'h0);
      chk("rst_src", 64'(creq_src), 64'h0);
      chk("rst_cnt", 64'(outs_cnt), 64'h0);
      chk("rst_err", 64'(err), 64'h0);
      chk("rst_resp", 64'(resp_valid), 64'h0);
    end else begin
      pop  = cresp_valid && (m_fifo.size() > 0);
      e_rv = '0;
      if (pop) e_rv[m_fifo[0]] = 1'b1;
      cg = (!m_hv || creq_allow_in) && ((m_fifo.size() < MO) || pop);
      found = 1'b0;
      w     = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && req_valid[(m_rr + k) % N]) begin
          found = 1'b1;
          w     = (m_rr + k) % N;
        end
      end
      grant   = found && cg;
      e_allow = '0;
      if (grant) e_allow[w] = 1'b1;

      chk("m_allow", 64'(req_allow), 64'(e_allow));
      chk("m_resp_valid", 64'(resp_valid), 64'(e_rv));
      chk("m_resp_data", 64'(resp_data), 64'(cresp));
      chk("m_creq_valid", 64'(creq_valid), 64'(m_hv));
      if (m_hv) begin
        chk("m_creq_data", 64'(creq), m_hdata);
        chk("m_creq_src", 64'(creq_src), 64'(m_hsrc));
      end
      chk("m_cnt", 64'(outs_cnt), 64'(m_fifo.size()));
      chk("m_err", 64'(err), 64'(m_err));

      if (cresp_valid && m_fifo.size() == 0) m_err = 1'b1;
      if (pop) void'(m_fifo.pop_front());
      if (grant) begin
        m_fifo.push_back(w);
        m_hv    = 1'b1;
        m_hdata = req_data[w*DW +: DW];
        m_hsrc  = w;
        m_rr    = (w + 1) % N;
      end else if (m_hv && creq_allow_in) begin
        m_hv = 1'b0;
      end
    end
  end

  task automatic run_random(input int n);
    for (int c = 0; c < n; c++) begin
      req_valid     = 4'($urandom());
      creq_allow_in = ($urandom_range(0, 9) < 7);
      cresp_valid   = ($urandom_range(0, 9) < 3);
      cresp         = {$urandom(), $urandom()};
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = {$urandom(), $urandom()};
      tick();
    end
  endtask

  initial begin : main
    logic [3:0] s3_exp [3];
    logic [3:0] s5_exp [4];
    rstn          = 1'b1;
    req_valid     = '0;
    req_data      = '0;
    creq_allow_in = 1'b0;
    cresp_valid   = 1'b0;
    cresp         = '0;
    #1 rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;

    // All four requesting, cache always ready, no responses: 0,1,2,3 then full.
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 64'h1000 + 64'(i);
    req_valid     = 4'hF;
    creq_allow_in = 1'b1;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      chk("s1_grant", 64'(req_allow), 64'(1) << i);
      if (i > 0) chk("s1_src", 64'(creq_src), 64'(i - 1));
      tick();
    end
    @(negedge clk);
    chk("s1_src_last", 64'(creq_src), 64'h3);
    chk("s1_cnt_full", 64'(outs_cnt), 64'h4);
    chk("s1_full_block", 64'(req_allow), 64'h0);
    tick();

    // Drain in order with payloads A0..A3, then a regrant starts at requester 0.
    req_valid = '0;
    for (int i = 0; i < N; i++) begin
      cresp_valid = 1'b1;
      cresp       = 64'hA0 + 64'(i);
      @(negedge clk);
      chk("s2_resp", 64'(resp_valid), 64'(1) << i);
      chk("s2_data", 64'(resp_data), 64'hA0 + 64'(i));
      tick();
    end
    cresp_valid = 1'b0;
    req_valid   = 4'hF;
    @(negedge clk);
    chk("s2_cnt_empty", 64'(outs_cnt), 64'h0);
    chk("s2_regrant", 64'(req_allow), 64'h1);
    tick();

    // Move rr_ptr to 2, then only 1 and 3 request (a response each cycle keeps room).
    req_valid   = 4'b0010;
    cresp_valid = 1'b1;
    @(negedge clk);
    chk("s3_pre", 64'(req_allow), 64'h2);
    tick();
    req_valid = 4'b1010;
    s3_exp    = '{4'b1000, 4'b0010, 4'b1000};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("s3_grant", 64'(req_allow), 64'(s3_exp[i]));
      tick();
    end

    // Stall the held request from requester 2 for three cycles.
    cresp_valid = 1'b0;
    req_data[2*DW +: DW] = 64'h55;
    req_valid = 4'b0100;
    @(negedge clk);
    chk("s4_grant", 64'(req_allow), 64'h4);
    tick();
    creq_allow_in = 1'b0;
    req_valid     = 4'hF;
    repeat (3) begin
      @(negedge clk);
      chk("s4_data", 64'(creq), 64'h55);
      chk("s4_src", 64'(creq_src), 64'h2);
      chk("s4_valid", 64'(creq_valid), 64'h1);
      chk("s4_allow", 64'(req_allow), 64'h0);
      tick();
    end
    creq_allow_in = 1'b1;
    @(negedge clk);
    chk("s4_release", 64'(req_allow), 64'h8);
    tick();
    @(negedge clk);
    chk("s4_next_src", 64'(creq_src), 64'h3);
    chk("s5_fill", 64'(req_allow), 64'h1);
    tick();

    // Full FIFO: blocked without a response, push+pop together with one.
    @(negedge clk);
    chk("s5_cnt", 64'(outs_cnt), 64'h4);
    chk("s5_blocked", 64'(req_allow), 64'h0);
    tick();
    cresp_valid = 1'b1;
    cresp       = 64'hB0;
    @(negedge clk);
    chk("s5_resp", 64'(resp_valid), 64'h8);
    chk("s5_allow", 64'(req_allow), 64'h2);
    tick();
    cresp_valid = 1'b0;
    req_valid   = '0;
    @(negedge clk);
    chk("s5_cnt_same", 64'(outs_cnt), 64'h4);
    tick();
    s5_exp = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
    for (int i = 0; i < 4; i++) begin
      cresp_valid = 1'b1;
      cresp       = 64'hC0 + 64'(i);
      @(negedge clk);
      chk("s5_route", 64'(resp_valid), 64'(s5_exp[i]));
      tick();
    end

    // Response with nothing outstanding: dropped, sticky error.
    cresp = 64'hDEAD;
    @(negedge clk);
    chk("s6_resp", 64'(resp_valid), 64'h0);
    chk("s6_err_pre", 64'(err), 64'h0);
    tick();
    cresp_valid = 1'b0;
    @(negedge clk);
    chk("s6_err", 64'(err), 64'h1);
    tick();
    repeat (3) tick();
    @(negedge clk);
    chk("s6_sticky", 64'(err), 64'h1);
    tick();

    // Random traffic, async reset mid-burst, more random traffic.
    run_random(500);
    @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    chk("ar_allow", 64'(req_allow), 64'h0);
    chk("ar_valid", 64'(creq_valid), 64'h0);
    chk("ar_data", 64'(creq), 64'h0);
    chk("ar_src", 64'(creq_src), 64'h0);
    chk("ar_cnt", 64'(outs_cnt), 64'h0);
    chk("ar_err", 64'(err), 64'h0);
    chk("ar_resp", 64'(resp_valid), 64'h0);
    tick();
    rstn = 1'b1;
    run_random(1500);

    req_valid   = '0;
    cresp_valid = 1'b0;
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
